// File: rtl/positions_to_mask.sv
// rtl/positions_to_mask.sv - rebuild an N-bit mask from a stream of bit positions
//
// Purpose: accumulates up to LANES bit positions per input beat into an N-bit
// mask. The frame closes with in_last, after which the mask, its population
// count and sticky error flags are held on the output until the consumer takes them.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid / in_ready    input beat handshake
//   in_pos                 LANES packed positions, lane k at [k*LOGN +: LOGN]
//   in_lane_en             per-lane enable
//   in_last                beat closes the frame
//   out_valid / out_ready  output handshake
//   out_mask               assembled bitmask
//   out_count              number of distinct set bits in out_mask
//   out_dup                a position repeated within the frame
//   out_oob                a position >= N was seen and dropped

module positions_to_mask #(
  parameter int N     = 256,
  parameter int LOGN  = (N > 1) ? $clog2(N) : 1,
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*LOGN-1:0] in_pos,
  input  logic [LANES-1:0]      in_lane_en,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          out_mask,
  output logic [LOGN:0]         out_count,
  output logic                  out_dup,
  output logic                  out_oob
);

  localparam logic [LOGN:0] N_EXT = (LOGN + 1)'(N);

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  state_t          state;
  state_t          state_nx;

  logic [N-1:0]    acc;
  logic [LOGN:0]   count;
  logic            dup;
  logic            oob;

  logic [N-1:0]    beat_mask;
  logic [LOGN:0]   beat_inc;
  logic            beat_dup;
  logic            beat_oob;
  logic [LOGN-1:0] lane_pos;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign out_mask  = acc;
  assign out_count = count;
  assign out_dup   = dup;
  assign out_oob   = oob;

  // Lanes are folded in order 0..LANES-1 onto a running copy of the
  // accumulator, so a repeat of an earlier lane in the same beat looks exactly
  // like a hit on a bit set by a previous beat. Only newly set bits bump the
  // count increment, which keeps out_count equal to the distinct-bit total.
  always_comb begin
    beat_mask = acc;
    beat_inc  = '0;
    beat_dup  = 1'b0;
    beat_oob  = 1'b0;
    lane_pos  = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_pos = in_pos[k*LOGN +: LOGN];
      if (in_lane_en[k]) begin
        if ({1'b0, lane_pos} >= N_EXT) begin
          beat_oob = 1'b1;
        end else if (beat_mask[lane_pos]) begin
          beat_dup = 1'b1;
        end else begin
          beat_mask[lane_pos] = 1'b1;
          beat_inc            = beat_inc + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ACCUM:   if (in_valid && in_last) state_nx = HOLD;
      HOLD:    if (out_ready)           state_nx = ACCUM;
      default: state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_nx;
    end
  end

  // No input is taken in HOLD, so the output fire and an input fire can never
  // coincide; the clear on output fire needs no bypass path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
      dup   <= 1'b0;
      oob   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc   <= beat_mask;
            count <= count + beat_inc;
            dup   <= dup | beat_dup;
            oob   <= oob | beat_oob;
          end
        end
        HOLD: begin
          if (out_ready) begin
            acc   <= '0;
            count <= '0;
            dup   <= 1'b0;
            oob   <= 1'b0;
          end
        end
        default: begin
          acc   <= '0;
          count <= '0;
          dup   <= 1'b0;
          oob   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_positions_to_mask.sv
// tb/tb_positions_to_mask.sv - randomized self-checking bench for positions_to_mask
//
// Purpose: drives position frames into an N=256 instance and an N=200 instance
// and compares outputs against a set-based reference model.

module tb_positions_to_mask;

  localparam int N     = 256;
  localparam int LOGN  = 8;
  localparam int LANES = 4;
  localparam int N2    = 200;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;

  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [LANES*LOGN-1:0] in_pos = '0;
  logic [LANES-1:0]      in_lane_en = '0;
  logic                  in_last = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [N-1:0]          out_mask;
  logic [LOGN:0]         out_count;
  logic                  out_dup;
  logic                  out_oob;

  logic                  b_in_valid = 1'b0;
  logic                  b_in_ready;
  logic [LANES*LOGN-1:0] b_in_pos = '0;
  logic [LANES-1:0]      b_in_lane_en = '0;
  logic                  b_in_last = 1'b0;
  logic                  b_out_valid;
  logic                  b_out_ready = 1'b0;
  logic [N2-1:0]         b_out_mask;
  logic [LOGN:0]         b_out_count;
  logic                  b_out_dup;
  logic                  b_out_oob;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: set of positions seen in the current frame
  int seen[int];
  bit exp_dup;
  bit exp_oob;

  always #5 clk = ~clk;

  positions_to_mask #(.N(N), .LOGN(LOGN), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pos(in_pos),
    .in_lane_en(in_lane_en), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
    .out_count(out_count), .out_dup(out_dup), .out_oob(out_oob)
  );

  positions_to_mask #(.N(N2), .LOGN(LOGN), .LANES(LANES)) dut_n200 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pos(b_in_pos),
    .in_lane_en(b_in_lane_en), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_mask(b_out_mask),
    .out_count(b_out_count), .out_dup(b_out_dup), .out_oob(b_out_oob)
  );

  function automatic logic [N-1:0] model_mask();
    logic [N-1:0] m = '0;
    foreach (seen[i]) m[i] = 1'b1;
    return m;
  endfunction

  task automatic model_clear();
    seen.delete();
    exp_dup = 1'b0;
    exp_oob = 1'b0;
  endtask

  task automatic model_beat(input int p0, input int p1, input int p2, input int p3,
                            input logic [3:0] en);
    int p[4];
    p = '{p0, p1, p2, p3};
    for (int k = 0; k < 4; k++) begin
      if (en[k]) begin
        if (p[k] >= N) exp_oob = 1'b1;
        else if (seen.exists(p[k])) exp_dup = 1'b1;
        else seen[p[k]] = 1;
      end
    end
  endtask

  // Presents one beat, waits (bounded) for it to fire, updates the model.
  // Returns #1 after the firing edge.
  task automatic send_beat(input int p0, input int p1, input int p2, input int p3,
                           input logic [3:0] en, input logic last);
    int t;
    in_valid   = 1'b1;
    in_pos     = {p3[7:0], p2[7:0], p1[7:0], p0[7:0]};
    in_lane_en = en;
    in_last    = last;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    n_cmp++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_beat(p0, p1, p2, p3, en);
  endtask

  task automatic accept_output();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    n_cmp++;
    if (out_mask !== '0 || out_count !== '0 || out_dup !== 1'b0 || out_oob !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: count=%0d dup=%b oob=%b mask_nonzero=%b required 0",
               out_count, out_dup, out_oob, |out_mask);
    end
  endtask

  task automatic test_basic();
    logic [N-1:0] exp_m;
    model_clear();
    send_beat(0, 5, 255, 0, 4'b0111, 1'b1);
    exp_m = '0;
    exp_m[0] = 1'b1; exp_m[5] = 1'b1; exp_m[255] = 1'b1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_mask !== exp_m || out_count !== 9'd3 ||
        out_dup !== 1'b0 || out_oob !== 1'b0) begin
      n_fail++;
      $display("FAIL basic: valid=%b count=%0d dup=%b oob=%b mask=%h required 1/3/0/0 %h",
               out_valid, out_count, out_dup, out_oob, out_mask, exp_m);
    end
    accept_output();
  endtask

  task automatic test_full();
    int perm[256];
    int j, tmp;
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    model_clear();
    out_ready = 1'b1;
    for (int b = 0; b < 64; b++)
      send_beat(perm[4*b], perm[4*b+1], perm[4*b+2], perm[4*b+3], 4'b1111, b == 63);
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_mask !== {N{1'b1}} ||
        out_count !== 9'd256 || out_dup !== 1'b0) begin
      n_fail++;
      $display("FAIL full_out: valid=%b in_ready=%b count=%0d dup=%b required 1/0/256/0",
               out_valid, in_ready, out_count, out_dup);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_one_cycle: valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_dup();
    model_clear();
    send_beat(7, 7, 9, 0, 4'b0111, 1'b0);
    send_beat(9, 0, 0, 0, 4'b0001, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_mask !== model_mask() || out_count !== 9'd2 ||
        out_dup !== 1'b1 || exp_dup !== 1'b1) begin
      n_fail++;
      $display("FAIL dup: valid=%b count=%0d dup=%b mask=%h required 1/2/1 %h",
               out_valid, out_count, out_dup, out_mask, model_mask());
    end
    accept_output();
  endtask

  task automatic test_backpressure();
    logic [N-1:0] exp_m;
    model_clear();
    send_beat($urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 0),
              $urandom_range(255, 0), 4'b1111, 1'b1);
    exp_m = model_mask();
    in_valid   = 1'b1;
    in_pos     = 32'h0a0b0c0d;
    in_lane_en = 4'b1111;
    in_last    = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_mask !== exp_m ||
          out_count !== seen.num() || out_dup !== exp_dup || out_oob !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable cyc%0d: valid=%b in_ready=%b count=%0d dup=%b required 1/0/%0d/%b",
                 c, out_valid, in_ready, out_count, out_dup, seen.num(), exp_dup);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    accept_output();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    model_clear();
    send_beat(42, 0, 0, 0, 4'b0001, 1'b1);
    n_cmp++;
    if (out_mask !== model_mask() || out_count !== 9'd1 || out_dup !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_next_frame: count=%0d dup=%b required 1/0", out_count, out_dup);
    end
    accept_output();
  endtask

  task automatic test_empty();
    model_clear();
    send_beat(1, 2, 3, 4, 4'b0000, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_mask !== '0 || out_count !== 9'd0 || out_dup !== 1'b0) begin
      n_fail++;
      $display("FAIL empty: valid=%b count=%0d dup=%b required 1/0/0", out_valid, out_count, out_dup);
    end
    accept_output();
  endtask

  task automatic test_random();
    int nb, hi;
    for (int f = 0; f < 12; f++) begin
      model_clear();
      nb = $urandom_range(6, 1);
      hi = (f % 2 == 0) ? 31 : 255;
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(1, 0) == 1) begin
          @(posedge clk); #1;
        end
        send_beat($urandom_range(hi, 0), $urandom_range(hi, 0), $urandom_range(hi, 0),
                  $urandom_range(hi, 0), 4'($urandom_range(15, 0)), b == nb - 1);
      end
      n_cmp++;
      if (out_valid !== 1'b1 || out_mask !== model_mask() || out_count !== seen.num() ||
          out_dup !== exp_dup || out_oob !== 1'b0) begin
        n_fail++;
        $display("FAIL random f%0d: valid=%b count=%0d dup=%b required 1/%0d/%b",
                 f, out_valid, out_count, out_dup, seen.num(), exp_dup);
      end
      repeat ($urandom_range(2, 0)) @(posedge clk);
      #1 accept_output();
    end
  endtask

  task automatic test_oob();
    logic [N2-1:0] exp_m;
    exp_m = '0;
    exp_m[10] = 1'b1;
    b_in_valid   = 1'b1;
    b_in_pos     = {8'd0, 8'd0, 8'd10, 8'd210};
    b_in_lane_en = 4'b0011;
    b_in_last    = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
    n_cmp++;
    if (b_out_valid !== 1'b1 || b_out_oob !== 1'b1 || b_out_mask !== exp_m ||
        b_out_count !== 9'd1 || b_out_dup !== 1'b0) begin
      n_fail++;
      $display("FAIL oob: valid=%b oob=%b count=%0d dup=%b required 1/1/1/0",
               b_out_valid, b_out_oob, b_out_count, b_out_dup);
    end
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    n_cmp++;
    if (b_in_ready !== 1'b1 || b_out_oob !== 1'b0) begin
      n_fail++;
      $display("FAIL oob_clear: in_ready=%b oob=%b required 1/0", b_in_ready, b_out_oob);
    end
  endtask

  task automatic test_reset_mid();
    model_clear();
    send_beat(50, 60, 0, 0, 4'b0011, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    send_beat(3, 0, 0, 0, 4'b0001, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_mask !== model_mask() || out_count !== 9'd1 || out_dup !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b count=%0d dup=%b required 1/1/0", out_valid, out_count, out_dup);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_hold: valid=%b in_ready=%b count=%0d required 0/1/0",
               out_valid, in_ready, out_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_dup();
    test_backpressure();
    test_empty();
    test_random();
    test_oob();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
